// File: rtl/read_controller.sv
// read_controller
// Read-side pointer/flag controller of the asynchronous FIFO. Runs entirely in
// the read clock domain: synchronizes the write pointer through two flops,
// owns the read pointer, drives the memory read port and produces the
// empty / almost-empty / level / underflow status.
//
// Ports
//   clkr        read clock (posedge)
//   resetr      synchronous active-high reset
//   read        read request from the consumer
//   wptr_in     write pointer from the write domain (unsynchronized)
//   rptr        registered read pointer to the write side (binary or Gray)
//   raddr       memory read address
//   rd_en       memory read strobe (read accepted this cycle)
//   rvalid      memory data valid, one cycle after rd_en
//   emptyflag   FIFO empty as seen from the read domain
//   aemptyflag  level <= AEMPTY_TH
//   rlevel      synchronized fill level, 0..2^ADDR_W
//   underflow   sticky: a read was attempted while empty
module read_controller #(
  parameter int ADDR_W    = 5,
  parameter int PTR_W     = ADDR_W + 1,
  parameter int AEMPTY_TH = 4,
  parameter int GRAY_XING = 0
) (
  input  logic              clkr,
  input  logic              resetr,
  input  logic              read,
  input  logic [PTR_W-1:0]  wptr_in,
  output logic [PTR_W-1:0]  rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_en,
  output logic              rvalid,
  output logic              emptyflag,
  output logic              aemptyflag,
  output logic [PTR_W-1:0]  rlevel,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_TH);

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0] wptr_s1_q, wptr_s2_q;
  logic [PTR_W-1:0] rptr_bin_q, rptr_bin_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             aempty_q, aempty_d;
  logic             rvalid_q;
  logic             underflow_q;
  logic             racc;
  logic [PTR_W-1:0] wptr_sb;

  always_comb begin
    racc       = read & ~empty_q;
    rptr_bin_d = rptr_bin_q + PTR_W'(racc);
    wptr_sb    = (GRAY_XING != 0) ? gray2bin(wptr_s2_q) : wptr_s2_q;
    // Flags are computed from the post-read pointer so an accepted read is
    // reflected on the same edge; the level wraps modulo 2^PTR_W.
    level_d    = wptr_sb - rptr_bin_d;
    empty_d    = (rptr_bin_d == wptr_sb);
    aempty_d   = (level_d <= AEMPTY_LVL);
    rptr_d     = (GRAY_XING != 0) ? bin2gray(rptr_bin_d) : rptr_bin_d;
  end

  always_ff @(posedge clkr) begin
    if (resetr) begin
      wptr_s1_q   <= '0;
      wptr_s2_q   <= '0;
      rptr_bin_q  <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      rvalid_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // Plain two-flop synchronizer: nothing between the stages.
      wptr_s1_q   <= wptr_in;
      wptr_s2_q   <= wptr_s1_q;
      rptr_bin_q  <= rptr_bin_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      rvalid_q    <= racc;
      if (read && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign rptr       = rptr_q;
  assign raddr      = rptr_bin_q[ADDR_W-1:0];
  assign rd_en      = racc;
  assign rvalid     = rvalid_q;
  assign emptyflag  = empty_q;
  assign aemptyflag = aempty_q;
  assign rlevel     = level_q;
  assign underflow  = underflow_q;

endmodule
